// File: rtl/axi_rd_pkg.sv
// Shared definitions for the AXI4 burst read master.
//   AXI_BURST_INCR      : ARBURST encoding for incrementing bursts
//   RESP_*              : RRESP encodings
//   BOUNDARY_4K         : bursts may not cross a multiple of this byte address
//   AXI_CACHE_DEFAULT   : ARCACHE value (modifiable, bufferable)
//   rd_state_e          : read master FSM states
//   axi_size()          : ARSIZE for a given data width in bits
package axi_rd_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned BOUNDARY_4K = 4096;

  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    StIdle,
    StAr,
    StR,
    StDone
  } rd_state_e;

  // log2 of the bus width in bytes
  function automatic int unsigned axi_size(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_master_rd_burst_if.sv
// AXI4 read-address and read-data channels between a read master and a slave.
//   master modport : drives AR payload/valid and rready; receives arready and R payload/valid
//   slave modport  : the mirror image
interface axi_master_rd_burst_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 64
);

  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  rready,
    output arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_rd_burst_len.sv
// Burst length calculator (combinational).
//   addr_lo   in  12      low 12 bits of the (bus-aligned) burst start address
//   remaining in  CNT_W   beats still to be requested (non-zero when the result is used)
//   arlen     out 8       min(remaining, MAX_BURST, beats left before the 4 KB boundary) - 1
module axi_rd_burst_len
  import axi_rd_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic [11:0]      addr_lo,
  input  logic [CNT_W-1:0] remaining,
  output logic [7:0]       arlen
);

  localparam int unsigned SizeLog2 = axi_size(DATA_W);

  logic [12:0] to_4k;
  logic [31:0] bound_beats;
  logic [31:0] rem_beats;
  logic [31:0] n_beats;

  always_comb begin
    to_4k       = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
    bound_beats = 32'(to_4k >> SizeLog2);
    rem_beats   = 32'(remaining);
    n_beats     = 32'(MAX_BURST);
    if (rem_beats < n_beats) begin
      n_beats = rem_beats;
    end
    if (bound_beats < n_beats) begin
      n_beats = bound_beats;
    end
    arlen = 8'(n_beats - 32'd1);
  end

endmodule

// File: rtl/axi_master_rd_burst.sv
// AXI4 read master: splits one user request of rd_beats beats into INCR bursts of at most
// MAX_BURST beats that never cross a 4 KB boundary, one burst outstanding at a time, and
// streams the returned data to the user.
//   clk, rst                  clock, synchronous active-high reset
//   rd_start/rd_addr/rd_beats request (sampled only while rd_ready)
//   rd_ready                  idle, request accepted
//   rd_data/rd_valid          read data stream, rd_data_ready is its back-pressure
//   rd_done                   one-cycle pulse when the whole request is finished
//   rd_err                    sticky error (only with AXI_RD_RESP_CHECK_EN)
//   m_axi                     AXI4 AR/R master port
// Build option: define AXI_RD_RESP_CHECK_EN to add rd_err with RRESP and RLAST checking;
// without it RRESP and RLAST are ignored.
module axi_master_rd_burst
  import axi_rd_pkg::*;
#(
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned AXI_ID    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_start,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [CNT_W-1:0]     rd_beats,
  output logic                 rd_ready,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  input  logic                 rd_data_ready,
  output logic                 rd_done,
`ifdef AXI_RD_RESP_CHECK_EN
  output logic                 rd_err,
`endif
  axi_master_rd_burst_if.master m_axi
);

  localparam int unsigned SizeLog2 = axi_size(DATA_W);
  localparam logic [ADDR_W-1:0] AlignMask = {ADDR_W{1'b1}} << SizeLog2;

  rd_state_e         st_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic              arvalid_q;
  logic              r_phase_q;
  logic              rd_ready_q;
  logic              rd_done_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  beat_cnt_q;

  logic [ADDR_W-1:0] next_addr;
  logic [CNT_W-1:0]  next_remaining;
  logic [ADDR_W-1:0] len_addr;
  logic [CNT_W-1:0]  len_remaining;
  logic [7:0]        len_arlen;
  logic              r_hs;
  logic              last_beat;

  // The burst length is computed for whichever burst is about to be issued: the first one
  // straight from the request inputs, later ones from the post-burst address/remaining.
  always_comb begin
    r_hs           = r_phase_q & m_axi.rvalid & rd_data_ready;
    last_beat      = (beat_cnt_q == CNT_W'(1));
    next_addr      = araddr_q + ((ADDR_W'(arlen_q) + ADDR_W'(1)) << SizeLog2);
    next_remaining = remaining_q - (CNT_W'(arlen_q) + CNT_W'(1));
    if (st_q == StIdle) begin
      len_addr      = rd_addr & AlignMask;
      len_remaining = rd_beats;
    end else begin
      len_addr      = next_addr;
      len_remaining = next_remaining;
    end
  end

  axi_rd_burst_len #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .MAX_BURST(MAX_BURST)
  ) u_burst_len (
    .addr_lo  (len_addr[11:0]),
    .remaining(len_remaining),
    .arlen    (len_arlen)
  );

`ifdef AXI_RD_RESP_CHECK_EN
  logic err_q;
  assign rd_err = err_q;
`else
  logic unused_r_status;
  assign unused_r_status = ^{m_axi.rresp, m_axi.rlast};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StIdle;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      r_phase_q   <= 1'b0;
      rd_ready_q  <= 1'b1;
      rd_done_q   <= 1'b0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
`ifdef AXI_RD_RESP_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      rd_done_q <= 1'b0;
      unique case (st_q)
        StIdle: begin
          if (rd_start) begin
            rd_ready_q <= 1'b0;
`ifdef AXI_RD_RESP_CHECK_EN
            err_q      <= 1'b0;
`endif
            if (rd_beats != '0) begin
              araddr_q    <= len_addr;
              arlen_q     <= len_arlen;
              arvalid_q   <= 1'b1;
              remaining_q <= rd_beats;
              st_q        <= StAr;
            end else begin
              rd_done_q <= 1'b1;
              st_q      <= StDone;
            end
          end
        end
        StAr: begin
          if (m_axi.arready) begin
            arvalid_q  <= 1'b0;
            r_phase_q  <= 1'b1;
            beat_cnt_q <= CNT_W'(arlen_q) + CNT_W'(1);
            st_q       <= StR;
          end
        end
        StR: begin
          if (r_hs) begin
            beat_cnt_q <= beat_cnt_q - CNT_W'(1);
`ifdef AXI_RD_RESP_CHECK_EN
            if (m_axi.rresp[1] || (m_axi.rlast != last_beat)) begin
              err_q <= 1'b1;
            end
`endif
            if (last_beat) begin
              r_phase_q   <= 1'b0;
              remaining_q <= next_remaining;
              if (next_remaining != '0) begin
                araddr_q  <= len_addr;
                arlen_q   <= len_arlen;
                arvalid_q <= 1'b1;
                st_q      <= StAr;
              end else begin
                rd_done_q <= 1'b1;
                st_q      <= StDone;
              end
            end
          end
        end
        StDone: begin
          rd_ready_q <= 1'b1;
          st_q       <= StIdle;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign rd_ready = rd_ready_q;
  assign rd_done  = rd_done_q;
  assign rd_data  = m_axi.rdata;
  // Data path is a pass-through gated by the R phase so beats are never buffered.
  assign rd_valid = r_phase_q & m_axi.rvalid;

  assign m_axi.arid    = 4'(AXI_ID);
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = arlen_q;
  assign m_axi.arsize  = 3'(SizeLog2);
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = AXI_CACHE_DEFAULT;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arqos   = 4'b0000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = r_phase_q & rd_data_ready;

endmodule

// File: tb/tb_axi_master_rd_burst.sv
// Testbench for axi_master_rd_burst (ADDR_W=30, DATA_W=64, MAX_BURST=16) with a slave model
// returning incrementing data after 0-3 cycles of random latency.
module tb_axi_master_rd_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_start;
  logic [29:0] rd_addr;
  logic [15:0] rd_beats;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        rd_data_ready = 1'b1;
  logic        rd_done;
`ifdef AXI_RD_RESP_CHECK_EN
  logic        rd_err;
  logic        err_at_done = 1'b0;
`endif

  axi_master_rd_burst_if #(.ADDR_W(30), .DATA_W(64)) axi ();

  axi_master_rd_burst #(
    .ADDR_W   (30),
    .DATA_W   (64),
    .CNT_W    (16),
    .MAX_BURST(16),
    .AXI_ID   (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_start     (rd_start),
    .rd_addr      (rd_addr),
    .rd_beats     (rd_beats),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_data_ready(rd_data_ready),
    .rd_done      (rd_done),
`ifdef AXI_RD_RESP_CHECK_EN
    .rd_err       (rd_err),
`endif
    .m_axi        (axi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  int          s_ph = 0;
  int          s_cnt = 0;
  int          s_left = 0;
  int unsigned s_rnd = 0;
  logic [63:0] data_ctr = '0;
  logic [63:0] err_beat = '1;

  always @(posedge clk) begin
    s_rnd <= $urandom_range(0, 3);
    if (rst) begin
      s_ph <= 0; s_cnt <= 0; s_left <= 0; data_ctr <= '0;
      axi.arready <= 1'b0; axi.rvalid <= 1'b0; axi.rlast <= 1'b0;
      axi.rresp <= 2'b00; axi.rdata <= '0;
    end else begin
      case (s_ph)
        0: if (axi.arvalid) begin
             if (s_cnt == 0) begin axi.arready <= 1'b1; s_ph <= 1; end
             else s_cnt <= s_cnt - 1;
           end
        1: begin
             axi.arready <= 1'b0;
             s_left <= int'(axi.arlen) + 1;
             s_cnt <= int'(s_rnd);
             s_ph <= 2;
           end
        2: if (s_cnt == 0) begin
             axi.rvalid <= 1'b1; axi.rdata <= data_ctr; axi.rlast <= (s_left == 1);
             axi.rresp <= (data_ctr == err_beat) ? 2'b10 : 2'b00;
             s_ph <= 3;
           end else s_cnt <= s_cnt - 1;
        3: if (axi.rready) begin
             data_ctr <= data_ctr + 64'd1;
             s_left <= s_left - 1;
             if (s_left == 1) begin
               axi.rvalid <= 1'b0; axi.rlast <= 1'b0; s_cnt <= int'(s_rnd); s_ph <= 0;
             end else if (s_rnd == 0) begin
               axi.rdata <= data_ctr + 64'd1; axi.rlast <= (s_left == 2);
               axi.rresp <= ((data_ctr + 64'd1) == err_beat) ? 2'b10 : 2'b00;
             end else begin
               axi.rvalid <= 1'b0; s_cnt <= int'(s_rnd) - 1; s_ph <= 2;
             end
           end
        default: s_ph <= 0;
      endcase
      if (rd_start && rd_ready) data_ctr <= '0;
    end
  end

  // ---------------- user-side ready driver ----------------
  bit rnd_en = 1'b0;
  always @(posedge clk) begin
    #1;
    rd_data_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  logic [29:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [63:0] data_q[$];
  int done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, mirror_err = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (axi.arvalid && axi.arready) begin
        ar_addr_q.push_back(axi.araddr);
        ar_len_q.push_back(axi.arlen);
      end
      if (rd_valid && rd_data_ready) begin
        data_q.push_back(rd_data);
        last_hs_cyc <= cyc;
      end
      if (rd_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
`ifdef AXI_RD_RESP_CHECK_EN
        err_at_done <= rd_err;
`endif
      end
      if (axi.rvalid && (axi.rready !== rd_data_ready)) mirror_err <= mirror_err + 1;
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [29:0]      addr;
    logic [15:0]      beats;
    logic             rnd;
    logic [1:0]       n_ar;
    logic [2:0][29:0] ar_addr;
    logic [2:0][7:0]  ar_len;
  } vec_t;

  function automatic vec_t mk(input logic [29:0] addr, input logic [15:0] beats,
                              input logic rnd, input logic [1:0] n,
                              input logic [29:0] a0, input logic [7:0] l0,
                              input logic [29:0] a1, input logic [7:0] l1,
                              input logic [29:0] a2, input logic [7:0] l2);
    vec_t v;
    v.addr = addr; v.beats = beats; v.rnd = rnd; v.n_ar = n;
    v.ar_addr[0] = a0; v.ar_len[0] = l0;
    v.ar_addr[1] = a1; v.ar_len[1] = l1;
    v.ar_addr[2] = a2; v.ar_len[2] = l2;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input bit hold_busy);
    int a0, d0, n0, m0;
    bit seen;
    a0 = ar_addr_q.size(); d0 = data_q.size(); n0 = done_cnt; m0 = mirror_err;
    rnd_en = v.rnd;
    @(posedge clk); #1;
    chk("rd_ready_before", rd_ready, 1);
    rd_addr = v.addr; rd_beats = v.beats; rd_start = 1'b1;
    @(posedge clk); #1;
    if (hold_busy) begin
      // a second request while busy must be ignored
      rd_addr = 30'h400; rd_beats = 16'd5;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    rd_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(posedge clk);
      seen = (done_cnt != n0);
    end
    if (!seen) begin
      n_vec++; n_miss++;
      $display("FAIL rd_done_timeout: no rd_done, addr %0h beats %0d", v.addr, v.beats);
    end
    repeat (3) @(posedge clk);
    #1;
    rnd_en = 1'b0;
    chk("ar_count", 64'(ar_addr_q.size() - a0), 64'(v.n_ar));
    for (int k = 0; k < int'(v.n_ar) && (a0 + k) < ar_addr_q.size(); k++) begin
      chk("araddr", ar_addr_q[a0 + k], v.ar_addr[k]);
      chk("arlen", ar_len_q[a0 + k], v.ar_len[k]);
    end
    chk("beat_count", 64'(data_q.size() - d0), 64'(v.beats));
    for (int k = 0; k < int'(v.beats) && (d0 + k) < data_q.size(); k++) begin
      chk("rd_data", data_q[d0 + k], 64'(k));
    end
    chk("done_pulses", 64'(done_cnt - n0), 1);
    if (v.beats != 0) chk("done_latency", 64'(done_cyc - last_hs_cyc), 1);
    chk("rready_mirror", 64'(mirror_err - m0), 0);
    chk("rd_ready_after", rd_ready, 1);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = mk(30'h8,        16'd3,  1'b0, 2'd1, 30'h8,   8'd2,  30'h0,     8'd0, 30'h0,   8'd0);
    vecs[1] = mk(30'h0,        16'd40, 1'b0, 2'd3, 30'h0,   8'd15, 30'h80,    8'd15, 30'h100, 8'd7);
    vecs[2] = mk(30'hFE0,      16'd8,  1'b0, 2'd2, 30'hFE0, 8'd3,  30'h1000,  8'd3, 30'h0,   8'd0);
    vecs[3] = mk(30'h0,        16'd40, 1'b1, 2'd3, 30'h0,   8'd15, 30'h80,    8'd15, 30'h100, 8'd7);
    vecs[4] = mk(30'hF88,      16'd20, 1'b0, 2'd2, 30'hF88, 8'd14, 30'h1000,  8'd4, 30'h0,   8'd0);
    vecs[5] = mk(30'hC,        16'd1,  1'b0, 2'd1, 30'h8,   8'd0,  30'h0,     8'd0, 30'h0,   8'd0);
    vecs[6] = mk(30'hFF8,      16'd2,  1'b1, 2'd2, 30'hFF8, 8'd0,  30'h1000,  8'd0, 30'h0,   8'd0);
    vecs[7] = mk(30'h3FFFFFF0, 16'd4,  1'b0, 2'd2, 30'h3FFFFFF0, 8'd1, 30'h0, 8'd1, 30'h0,   8'd0);

    rst = 1'b1; rd_start = 1'b0; rd_addr = '0; rd_beats = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_ready", rd_ready, 1);
    chk("reset_arvalid", axi.arvalid, 0);
    chk("reset_rready", axi.rready, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_done", rd_done, 0);
    chk("reset_araddr", axi.araddr, 0);
    chk("reset_arlen", axi.arlen, 0);
    chk("ar_constants", {axi.arid, axi.arsize, axi.arburst, axi.arlock, axi.arcache,
                         axi.arprot, axi.arqos},
        {4'd0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
`ifdef AXI_RD_RESP_CHECK_EN
    chk("reset_rd_err", rd_err, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0);

    // rd_start held while busy
    run_vec(vecs[0], 1'b1);

    // zero-beat request: rd_done next cycle, no AXI traffic
    begin
      int a0;
      a0 = ar_addr_q.size();
      @(posedge clk); #1;
      rd_addr = 30'h100; rd_beats = 16'd0; rd_start = 1'b1;
      @(posedge clk); #1;
      rd_start = 1'b0;
      chk("zero_rd_done", rd_done, 1);
      chk("zero_rd_ready_busy", rd_ready, 0);
      @(posedge clk); #1;
      chk("zero_rd_done_clear", rd_done, 0);
      chk("zero_rd_ready_back", rd_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("zero_no_ar", 64'(ar_addr_q.size() - a0), 0);
    end

    // reset in the middle of a 40-beat read
    begin
      int d0;
      bit got;
      d0 = data_q.size();
      @(posedge clk); #1;
      rd_addr = 30'h0; rd_beats = 16'd40; rd_start = 1'b1;
      @(posedge clk); #1;
      rd_start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
        @(posedge clk);
        got = (data_q.size() >= d0 + 5);
      end
      if (!got) begin
        n_vec++; n_miss++;
        $display("FAIL midreset_timeout: beats seen %0d, expected at least 5", data_q.size() - d0);
      end
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midreset_arvalid", axi.arvalid, 0);
      chk("midreset_rready", axi.rready, 0);
      chk("midreset_rd_ready", rd_ready, 1);
      chk("midreset_rd_valid", rd_valid, 0);
      rst = 1'b0;
    end
    run_vec(vecs[2], 1'b0);

`ifdef AXI_RD_RESP_CHECK_EN
    err_beat = 64'd1;
    run_vec(vecs[0], 1'b0);
    chk("err_at_done", err_at_done, 1);
    chk("err_sticky", rd_err, 1);
    err_beat = '1;
    run_vec(vecs[0], 1'b0);
    chk("err_cleared_at_done", err_at_done, 0);
    chk("err_cleared", rd_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
